// File: rtl/cwe_job_scheduler_if.sv
// cwe_job_scheduler_if: request, source-FIFO, encoder-core and codeword-output signals of the job scheduler.
interface cwe_job_scheduler_if #(
    parameter int NREQ = 2,
    parameter int CW_W = 18
);
    logic [NREQ-1:0] req, grant, src_bit, src_empty, src_pop;
    logic            enc_start, enc_bin_msg, enc_fifoempty, enc_readfifo, enc_ready, enc_done, enc_rst_b;
    logic [CW_W-1:0] enc_cw_word, out_word;
    logic [1:0]      out_tag;
    logic            out_valid, out_last, busy, err_timeout, err_count;
    modport master (
        input  req, src_bit, src_empty, enc_readfifo, enc_cw_word, enc_ready, enc_done,
        output grant, src_pop, enc_start, enc_bin_msg, enc_fifoempty, enc_rst_b,
               out_valid, out_word, out_tag, out_last, busy, err_timeout, err_count
    );
    modport slave (
        output req, src_bit, src_empty, enc_readfifo, enc_cw_word, enc_ready, enc_done,
        input  grant, src_pop, enc_start, enc_bin_msg, enc_fifoempty, enc_rst_b,
               out_valid, out_word, out_tag, out_last, busy, err_timeout, err_count
    );
endinterface

// File: rtl/cwe_job_scheduler.sv
// cwe_job_scheduler: round-robin sharing of one constant-weight encoder core between NREQ message sources.
// Define CWE_WDOG_EN to add the RUN-state watchdog and the ABORT recovery state.
module cwe_job_scheduler #(
    parameter int NREQ          = 2,
    parameter int CW_W          = 18,
    parameter int WORDS_PER_JOB = 10,
    parameter int WDOG_MAX      = 4095
) (
    input logic clk,
    input logic rst_b,
    cwe_job_scheduler_if.master bus
);
`ifdef CWE_WDOG_EN
    typedef enum logic [2:0] {IDLE, GRANT, START, RUN, DONE, ABORT} state_t;
`else
    typedef enum logic [2:0] {IDLE, GRANT, START, RUN, DONE} state_t;
`endif
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    state_t          state, state_nx;
    logic [1:0]      owner, rr_ptr, winner, owner_inc;
    logic [NREQ-1:0] owner_oh;
    logic [7:0]      word_cnt;
    logic            has_owner, job_end;
    assign owner_oh  = ONE << owner;
    assign owner_inc = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
    // Scan downward so the requester closest above rr_ptr is the last (winning) assignment
    always_comb begin
        winner = rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (|(bus.req & (ONE << ((int'(rr_ptr) + i) % NREQ)))) winner = 2'((int'(rr_ptr) + i) % NREQ);
    end
`ifdef CWE_WDOG_EN
    logic [11:0] wdog;
    logic        err_to;
    assign job_end         = state == DONE || state == ABORT;
    assign bus.enc_rst_b   = state != ABORT;
    assign bus.err_timeout = err_to;
    // In ABORT the counter is reused to time the two-cycle core reset
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            wdog   <= '0;
            err_to <= 1'b0;
        end else begin
            if (state == GRANT) wdog <= '0;
            else if (state == RUN)
                wdog <= (bus.enc_ready || bus.enc_readfifo || bus.enc_done || state_nx != RUN) ? '0 : wdog + 12'd1;
            else if (state == ABORT) wdog <= wdog + 12'd1;
            if (state == ABORT) err_to <= 1'b1;
        end
`else
    assign job_end         = state == DONE;
    assign bus.enc_rst_b   = 1'b1;
    assign bus.err_timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |bus.req ? GRANT : IDLE;
            GRANT:   state_nx = START;
            START:   state_nx = RUN;
`ifdef CWE_WDOG_EN
            RUN:     state_nx = bus.enc_done ? DONE : (wdog == 12'(WDOG_MAX)) ? ABORT : RUN;
            ABORT:   state_nx = wdog[0] ? IDLE : ABORT;
`else
            RUN:     state_nx = bus.enc_done ? DONE : RUN;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        has_owner         = state inside {GRANT, START, RUN, DONE};
        bus.grant         = has_owner ? owner_oh : '0;
        bus.src_pop       = ((state == START || state == RUN) && bus.enc_readfifo) ? owner_oh : '0;
        bus.enc_start     = state == START;
        bus.enc_bin_msg   = |(bus.src_bit & owner_oh);
        bus.enc_fifoempty = has_owner ? |(bus.src_empty & owner_oh) : 1'b1;
        bus.busy          = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            owner         <= '0;
            rr_ptr        <= '0;
            word_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_word  <= '0;
            bus.out_tag   <= '0;
            bus.out_last  <= 1'b0;
            bus.err_count <= 1'b0;
        end else begin
            bus.out_valid <= state == RUN && bus.enc_ready;
            if (state == IDLE && |bus.req) owner <= winner;
            if (state == GRANT) word_cnt <= '0;
            if (state == RUN && bus.enc_ready) begin
                bus.out_word <= bus.enc_cw_word;
                bus.out_tag  <= owner;
                bus.out_last <= word_cnt == 8'(WORDS_PER_JOB - 1);
                word_cnt     <= word_cnt + 8'd1;
            end
            if (state == DONE && word_cnt != 8'(WORDS_PER_JOB)) bus.err_count <= 1'b1;
            if (job_end) rr_ptr <= owner_inc;
        end
endmodule
